// File: rtl/activation_unit.sv
// activation_unit: post-accumulation output stage.
// Each time the accumulator's full flag rises, its two results are captured,
// passed one per cycle through optional ReLU, a rounding arithmetic right
// shift and signed saturation, and queued in a small FIFO.
// The FIFO is presented to the consumer as a valid/ready stream.
module activation_unit #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4   // power of two, at least 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_full,
  input  logic [ACC_W-1:0] acc_mem_0,
  input  logic [ACC_W-1:0] acc_mem_1,
  input  logic             relu_en,
  input  logic [4:0]       shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             sat_flag,
  output logic             missed
);

  // ---------------------------------------------------------------------------
  // Local types and constants
  // ---------------------------------------------------------------------------
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Two guard bits: one for the rounding carry, one to keep the sign intact.
  localparam int V_W   = ACC_W + 2;

  localparam logic signed [V_W-1:0] SAT_MAX = V_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [V_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROC0 = 2'd1,
    PROC1 = 2'd2
  } state_t;

  typedef struct packed {
    logic             last;
    logic [OUT_W-1:0] data;
  } entry_t;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } quant_t;

  // ---------------------------------------------------------------------------
  // Quantizer: ReLU -> round-half-up arithmetic shift -> saturate
  // ---------------------------------------------------------------------------
  function automatic quant_t quantize(input logic [ACC_W-1:0] x,
                                      input logic             relu,
                                      input logic [4:0]       sh);
    logic signed [V_W-1:0] v;
    quant_t                q;
    v = {{2{x[ACC_W-1]}}, x};
    if (relu && x[ACC_W-1]) begin
      v = '0;
    end
    if (sh != 5'd0) begin
      v = v + (V_W'(1) << (sh - 5'd1));
    end
    v = v >>> sh;
    if (v > SAT_MAX) begin
      q.sat  = 1'b1;
      q.data = SAT_MAX[OUT_W-1:0];
    end else if (v < SAT_MIN) begin
      q.sat  = 1'b1;
      q.data = SAT_MIN[OUT_W-1:0];
    end else begin
      q.sat  = 1'b0;
      q.data = v[OUT_W-1:0];
    end
    return q;
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  state_t             state, state_next;
  logic               acc_full_q;
  logic               trigger;

  logic [ACC_W-1:0]   cap0, cap1;
  logic               cap_relu;
  logic [4:0]         cap_shift;

  logic               capture_en;
  logic               drop_trigger;
  logic               push_req;
  logic               sel_last;

  logic [ACC_W-1:0]   proc_value;
  quant_t             proc_q;
  entry_t             push_entry;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_full;
  logic               push, pop;
  entry_t             head;

  // ---------------------------------------------------------------------------
  // Trigger detection
  // ---------------------------------------------------------------------------
  // Delayed copy of the full flag; a trigger is its 0 -> 1 transition.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      acc_full_q <= 1'b0;
    end else begin
      acc_full_q <= acc_full;
    end
  end

  assign trigger = acc_full && !acc_full_q;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a PROC state advances only on the cycle its element is pushed.
  always_comb begin
    // NOTE: default first so no path through the block leaves state_next
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (trigger)    state_next = PROC0;
      PROC0:   if (!fifo_full) state_next = PROC1;
      PROC1:   if (!fifo_full) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // FSM outputs: capture, drop detection, push request and element select.
  always_comb begin
    capture_en   = 1'b0;
    drop_trigger = 1'b0;
    push_req     = 1'b0;
    sel_last     = 1'b0;
    busy         = 1'b1;
    unique case (state)
      IDLE: begin
        busy       = 1'b0;
        capture_en = trigger;
      end
      PROC0: begin
        push_req     = 1'b1;
        drop_trigger = trigger;
      end
      PROC1: begin
        push_req     = 1'b1;
        sel_last     = 1'b1;
        drop_trigger = trigger;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture registers: frozen for the whole pair, untouched by dropped triggers
  // ---------------------------------------------------------------------------
  // Latch the pair and its controls on an accepted trigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap0      <= '0;
      cap1      <= '0;
      cap_relu  <= 1'b0;
      cap_shift <= '0;
    end else if (capture_en) begin
      cap0      <= acc_mem_0;
      cap1      <= acc_mem_1;
      cap_relu  <= relu_en;
      cap_shift <= shift;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: one quantizer shared by both elements
  // ---------------------------------------------------------------------------
  assign proc_value      = sel_last ? cap1 : cap0;
  assign proc_q          = quantize(proc_value, cap_relu, cap_shift);
  assign push_entry.last = sel_last;
  assign push_entry.data = proc_q.data;

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  // Space is judged on the registered count, so a same-cycle pop never makes
  // room for a push.
  assign fifo_full = (count == CNT_W'(DEPTH));
  assign push      = push_req && !fifo_full;
  assign pop       = out_valid && out_ready;

  // Storage write; pointer wrap is the natural power-of-two rollover.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the count gates every read, so
    // stale contents are never observed.
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head.data : '0;
  assign out_last  = out_valid ? head.last : 1'b0;

  // ---------------------------------------------------------------------------
  // Sticky status flags, cleared only by reset
  // ---------------------------------------------------------------------------
  // Record any clamped push and any trigger arriving while a pair is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag <= 1'b0;
      missed   <= 1'b0;
    end else begin
      if (push && proc_q.sat) sat_flag <= 1'b1;
      if (drop_trigger)       missed   <= 1'b1;
    end
  end

endmodule
